// File: rtl/tick_scheduler.sv
// tick_scheduler: sequences an SNN core through a run of fixed-period timesteps
module tick_scheduler #(
  parameter int          NUM_NEURONS = 256,
  parameter int          NUM_TICKS   = 16,
  parameter logic [31:0] TICK_PERIOD = 32'd4000,
  localparam int         NW          = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1,
  localparam int         TW          = NUM_TICKS > 1 ? $clog2(NUM_TICKS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          input_buffer_empty,
  input  logic          neuron_ready,
  output logic          neuron_valid,
  output logic [NW-1:0] neuron_idx,
  output logic          tick,
  output logic [TW-1:0] tick_idx,
  output logic          busy,
  output logic          done
);
  typedef enum logic [2:0] {IDLE, DRAIN, SCAN, WAIT, TICK, DONE} state_t;
  state_t      state, nxt;
  logic [31:0] period_cnt;
  logic        hs, last_n, last_t, counting;
  assign hs       = neuron_valid & neuron_ready;
  assign last_n   = neuron_idx == NW'(NUM_NEURONS - 1);
  assign last_t   = tick_idx == TW'(NUM_TICKS - 1);
  assign counting = state inside {DRAIN, SCAN, WAIT};
  // next state; abort overrides every transition, including a start in IDLE
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? DRAIN : IDLE;
      DRAIN:   nxt = input_buffer_empty ? SCAN : DRAIN;
      SCAN:    nxt = hs && last_n ? WAIT : SCAN;
      WAIT:    nxt = period_cnt >= TICK_PERIOD - 32'd2 ? TICK : WAIT;
      TICK:    nxt = last_t ? DONE : DRAIN;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // state, counters and outputs; outputs are registered decodes of the next state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      neuron_valid <= 1'b0;
      neuron_idx   <= '0;
      tick         <= 1'b0;
      tick_idx     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      period_cnt   <= '0;
    end else begin
      state        <= nxt;
      neuron_valid <= nxt == SCAN;
      tick         <= nxt == TICK;
      done         <= nxt == DONE;
      busy         <= nxt != IDLE;
      neuron_idx   <= nxt != SCAN ? '0 : hs ? neuron_idx + 1'b1 : neuron_idx;
      tick_idx     <= nxt == IDLE ? '0 : state == TICK && nxt == DRAIN ? tick_idx + 1'b1 : tick_idx;
      period_cnt   <= nxt == IDLE || (nxt == DRAIN && state != DRAIN) ? '0 :
                      counting && period_cnt != '1 ? period_cnt + 32'd1 : period_cnt;
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: timeline-model checks of tick_scheduler with directed and random stimulus
module tb_tick_scheduler;
  localparam int NN = 4, NT = 2, P = 16, MAXC = 512;
  logic       clk = 0, rst = 0, start = 0, abort = 0, empty = 0, ready = 0;
  logic       neuron_valid, tick, busy, done;
  logic [1:0] neuron_idx;
  logic [0:0] tick_idx;
  int         checks = 0, errors = 0, len;
  bit         emp[MAXC], rdy[MAXC], st[MAXC];
  logic [6:0] expv[MAXC], obs[MAXC];

  always #5 clk = ~clk;

  tick_scheduler #(.NUM_NEURONS(NN), .NUM_TICKS(NT), .TICK_PERIOD(32'(P))) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .input_buffer_empty(empty), .neuron_ready(ready),
    .neuron_valid(neuron_valid), .neuron_idx(neuron_idx), .tick(tick),
    .tick_idx(tick_idx), .busy(busy), .done(done)
  );

  function automatic logic [6:0] pack(bit t, bit d, bit b, bit v, int idx, int ti);
    return {t, d, b, v, 2'(idx), 1'(ti)};
  endfunction

  // Expected timeline indexed by edge number (edge 0 accepts start): each tick's
  // drain ends on the first empty sample, the scan ends on the NN-th ready sample,
  // and the tick lands at max(scan end + 1, drain start + P - 1).
  task automatic build(input int mode, input int abort_at);
    int d, s, w, t, h, x;
    for (int e = 0; e < MAXC; e++) begin
      emp[e]  = e >= MAXC - 64 || (mode == 2 ? e > 30 : mode == 3 ? $urandom_range(3) != 0 : 1'b1);
      rdy[e]  = e >= MAXC - 64 || (mode == 1 ? e % 2 == 1 : mode == 3 ? $urandom_range(1) == 1 : 1'b1);
      st[e]   = e == 0;
      expv[e] = '0;
    end
    d = 0;
    for (int k = 0; k < NT; k++) begin
      s = d + 1;
      while (!emp[s]) s++;
      for (x = d; x < s; x++) expv[x] = pack(0, 0, 1, 0, 0, k);
      h = 0;
      x = s;
      while (h < NN) begin
        expv[x] = pack(0, 0, 1, 1, h, k);
        x++;
        if (rdy[x]) h++;
      end
      w = x;
      t = (w + 1 > d + P - 1) ? w + 1 : d + P - 1;
      for (x = w; x < t; x++) expv[x] = pack(0, 0, 1, 0, 0, k);
      expv[t] = pack(1, 0, 1, 0, 0, k);
      d = t + 1;
    end
    expv[d] = pack(0, 1, 1, 0, 0, NT - 1);
    len = d + 4;
    if (mode >= 3) for (int e = 1; e <= d + 1; e++) st[e] = 1'($urandom_range(1));
    if (abort_at >= 0) begin
      for (int e = abort_at; e < MAXC; e++) expv[e] = '0;
      len = abort_at + 4;
    end
  endtask

  task automatic drive(input int abort_at);
    for (int e = 0; e < len; e++) begin
      start = st[e];
      empty = emp[e];
      ready = rdy[e];
      abort = e == abort_at;
      @(posedge clk);
      @(negedge clk);
      obs[e] = {tick, done, busy, neuron_valid, neuron_idx, tick_idx};
    end
    start = 0; abort = 0; ready = 0; empty = 0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({tick, done, busy, neuron_valid, neuron_idx, tick_idx} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got %b exp 0000000", {tick, done, busy, neuron_valid, neuron_idx, tick_idx});
    end
    @(negedge clk);
    rst = 1;
    start = 1; empty = 1; ready = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 10 && !neuron_valid; i++) @(negedge clk);
    checks++;
    if (neuron_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_reach_scan got valid=%b exp 1", neuron_valid);
    end
    #2 rst = 0;
    #1;
    checks++;
    if ({tick, done, busy, neuron_valid, neuron_idx, tick_idx} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_scan got %b exp 0000000", {tick, done, busy, neuron_valid, neuron_idx, tick_idx});
    end
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, neuron_valid} !== 2'b0) begin
      errors++;
      $display("FAIL reset_idle_after_release got busy,valid=%b exp 00", {busy, neuron_valid});
    end
    empty = 0; ready = 0;
  endtask

  task automatic test_basic_run;
    build(0, -1);
    drive(-1);
    for (int e = 0; e < len; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL basic_run cyc %0d got %b exp %b (tick,done,busy,valid,idx,tidx)", e, obs[e], expv[e]);
      end
    end
  endtask

  task automatic test_ready_toggle;
    build(1, -1);
    drive(-1);
    for (int e = 0; e < len; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL ready_toggle cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
    end
  endtask

  task automatic test_overrun;
    build(2, -1);
    drive(-1);
    for (int e = 0; e < len; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL overrun cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
    end
  endtask

  task automatic test_abort;
    build(0, 25);
    drive(25);
    for (int e = 0; e < len; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL abort_in_wait cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
    end
    start = 1; abort = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0; abort = 0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_with_start got busy=%b exp 0", busy);
    end
    build(0, -1);
    drive(-1);
    for (int e = 0; e < len; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL run_after_abort cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int ticks;
    build(4, -1);
    drive(-1);
    ticks = 0;
    for (int e = 0; e < len; e++) begin
      ticks += int'(obs[e][6]);
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL start_while_busy cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
    end
    checks++;
    if (ticks != NT) begin
      errors++;
      $display("FAIL tick_count got %0d exp %0d", ticks, NT);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      build(3, -1);
      drive(-1);
      for (int e = 0; e < len; e++) begin
        checks++;
        if (obs[e] !== expv[e]) begin
          errors++;
          $display("FAIL random run %0d cyc %0d got %b exp %b", r, e, obs[e], expv[e]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_run;
    test_ready_toggle;
    test_overrun;
    test_abort;
    test_start_while_busy;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
